// File: rtl/game_pkg.sv
// Shared constants and types for the 3x3 fire/gold game front end.
package game_pkg;
  localparam int N_ROWS = 3;
  localparam int N_COLS = 3;
  localparam int N_PADS = N_ROWS * N_COLS;

  typedef enum logic [1:0] {SCAN_C0, SCAN_C1, SCAN_C2, UPDATE} scan_state_e;

  // Bitmap position of the pad at [row][col].
  localparam int unsigned KEY_IDX [N_ROWS][N_COLS] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}};
endpackage

// File: rtl/sweep_debounce.sv
// One-bit debouncer that counts whole sweeps of disagreement before toggling.
module sweep_debounce #(
  parameter int DEB_SWEEPS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic sample,
  output logic out
);
  localparam int CW = $clog2(DEB_SWEEPS + 1);
  localparam logic [CW:0] DEB_LAST = DEB_SWEEPS[CW:0];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          out_q, out_d;

  always_comb begin
    cnt_d   = cnt_q;
    out_d   = out_q;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    if (en && !hold) begin
      if (sample == out_q) begin
        cnt_d = '0;
      end else if (cnt_inc == DEB_LAST) begin
        out_d = ~out_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;
endmodule

// File: rtl/box_pad_scanner.sv
// Scans the 3x3 active-low pad matrix, debounces pads and buttons per sweep,
// and rejects sweeps with too many pads pressed as ghosting.
module box_pad_scanner
  import game_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SWEEPS = 4,
  parameter int MAX_KEYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col_n,
  input  logic              start_btn_n,
  input  logic              super_sw_n,
  output logic [N_PADS-1:0] box,
  output logic              box_changed,
  output logic              start,
  output logic              super_on
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  scan_state_e       state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [N_COLS-1:0] col_n_q, col_n_d;
  logic [N_PADS-1:0] snap_q, snap_d;
  logic [1:0]        scan_col;

  logic [N_PADS-1:0] box_w, box_prev_q, box_prev_d;
  logic              start_lvl, start_prev_q, start_prev_d;
  logic              super_lvl;
  logic              upd, ghost;

  assign scan_col = state_q;

  // Rows are captured only on the last dwell cycle; earlier cycles let the lines settle.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + 1'b1;
    col_n_d = col_n_q;
    snap_d  = snap_q;
    if (state_q == UPDATE) begin
      state_d = SCAN_C0;
      dwell_d = '0;
      col_n_d = 3'b110;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          if (scan_col == 2'(c)) snap_d[KEY_IDX[r][c]] = ~row_n[r];
      case (state_q)
        SCAN_C0: begin state_d = SCAN_C1; col_n_d = 3'b101; end
        SCAN_C1: begin state_d = SCAN_C2; col_n_d = 3'b011; end
        default: begin state_d = UPDATE;  col_n_d = 3'b110; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SCAN_C0;
      dwell_q <= '0;
      col_n_q <= 3'b110;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      col_n_q <= col_n_d;
      snap_q  <= snap_d;
    end
  end

  assign upd   = (state_q == UPDATE);
  assign ghost = $countones(snap_q) > MAX_KEYS;

  for (genvar k = 0; k < N_PADS; k++) begin : g_pad
    sweep_debounce #(.DEB_SWEEPS(DEB_SWEEPS)) u_deb (
      .clk(clk), .rst(rst), .en(upd), .hold(ghost), .sample(snap_q[k]), .out(box_w[k])
    );
  end

  // Buttons keep debouncing through ghosted sweeps.
  sweep_debounce #(.DEB_SWEEPS(DEB_SWEEPS)) u_start (
    .clk(clk), .rst(rst), .en(upd), .hold(1'b0), .sample(~start_btn_n), .out(start_lvl)
  );
  sweep_debounce #(.DEB_SWEEPS(DEB_SWEEPS)) u_super (
    .clk(clk), .rst(rst), .en(upd), .hold(1'b0), .sample(~super_sw_n), .out(super_lvl)
  );

  always_comb begin
    box_prev_d   = box_w;
    start_prev_d = start_lvl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_prev_q   <= '0;
      start_prev_q <= 1'b0;
    end else begin
      box_prev_q   <= box_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign col_n       = col_n_q;
  assign box         = box_w;
  assign box_changed = (box_w != box_prev_q);
  assign start       = start_lvl & ~start_prev_q;
  assign super_on    = super_lvl;
endmodule

// File: tb/tb_box_pad_scanner.sv
// Directed plus random sweeps against a sweep-level behavioural model of the pad scanner.
module tb_box_pad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int MAXK     = 2;
  localparam int SWEEP    = 3 * SCAN_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] row_n, col_n;
  logic       start_btn_n = 1'b1, super_sw_n = 1'b1;
  logic [8:0] box;
  logic       box_changed, start, super_on;
  logic [8:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int mcnt [11];
  bit mout [11];

  box_pad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SWEEPS(DEB), .MAX_KEYS(MAXK)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .start_btn_n(start_btn_n), .super_sw_n(super_sw_n),
    .box(box), .box_changed(box_changed), .start(start), .super_on(super_on)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed pad pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 3; r++) row_n[r] = ~|(pressed[r*3 +: 3] & ~col_n);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] exp_col(input int cyc);
    int c;
    logic [2:0] v;
    c = cyc / SCAN_DIV;
    v = 3'b110;
    if (c < 3) v = 3'b111 ^ (3'b001 << c);
    return v;
  endfunction

  function automatic logic [8:0] model_box();
    logic [8:0] b;
    for (int k = 0; k < 9; k++) b[k] = mout[k];
    return b;
  endfunction

  // A bit flips once its input has disagreed for DEB consecutive sweeps; crowded sweeps freeze pads.
  task automatic model_sweep(output bit exp_start);
    bit [10:0] smp;
    bit ghost, old_start;
    smp       = {~super_sw_n, ~start_btn_n, pressed};
    ghost     = $countones(pressed) > MAXK;
    old_start = mout[9];
    for (int k = 0; k < 11; k++) begin
      if (!(k < 9 && ghost)) begin
        if (smp[k] == mout[k]) mcnt[k] = 0;
        else begin
          mcnt[k]++;
          if (mcnt[k] == DEB) begin
            mout[k] = !mout[k];
            mcnt[k] = 0;
          end
        end
      end
    end
    exp_start = mout[9] && !old_start;
  endtask

  task automatic run_sweep(input string tag);
    logic [8:0] prev_box;
    int nchg, nstart;
    bit exp_start;
    prev_box = model_box();
    nchg = 0;
    nstart = 0;
    model_sweep(exp_start);
    for (int i = 0; i < SWEEP; i++) begin
      chk({tag, " col_n"}, 32'(col_n), 32'(exp_col(i)));
      @(posedge clk);
      #1;
      if (box_changed) nchg++;
      if (start) nstart++;
    end
    chk({tag, " box"}, 32'(box), 32'(model_box()));
    chk({tag, " box_changed"}, nchg, (model_box() != prev_box) ? 1 : 0);
    chk({tag, " start"}, nstart, exp_start ? 1 : 0);
    chk({tag, " super"}, 32'(super_on), 32'(mout[10]));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pressed = '0;
    start_btn_n = 1'b1;
    super_sw_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst box", 32'(box), 0);
    chk("rst box_changed", 32'(box_changed), 0);
    chk("rst start", 32'(start), 0);
    chk("rst super", 32'(super_on), 0);
    chk("rst col_n", 32'(col_n), 32'(3'b110));
    for (int k = 0; k < 11; k++) begin
      mcnt[k] = 0;
      mout[k] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    run_sweep("idle");

    pressed = 9'b000100000;
    repeat (2) run_sweep("single");
    chk("single box", 32'(box), 32'(9'b000100000));
    pressed = '0;
    repeat (2) run_sweep("single_rel");
    chk("single_rel box", 32'(box), 0);

    pressed = 9'b000000001;
    run_sweep("bounce");
    pressed = '0;
    repeat (3) run_sweep("bounce_rel");

    pressed = 9'b100010001;
    repeat (4) run_sweep("ghost");
    chk("ghost box", 32'(box), 0);
    pressed = 9'b000010001;
    repeat (2) run_sweep("ghost_rel");
    chk("ghost_rel box", 32'(box), 32'(9'b000010001));
    pressed = '0;
    repeat (2) run_sweep("clear");

    start_btn_n = 1'b0;
    super_sw_n  = 1'b0;
    repeat (5) run_sweep("buttons");
    start_btn_n = 1'b1;
    super_sw_n  = 1'b1;
    repeat (3) run_sweep("buttons_rel");

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        pressed = '0;
        repeat ($urandom_range(0, 3)) pressed[$urandom_range(0, 8)] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) start_btn_n = ~start_btn_n;
      if ($urandom_range(0, 3) == 0) super_sw_n = ~super_sw_n;
      run_sweep("random");
    end

    do_reset();
    pressed = 9'b000000001;
    super_sw_n = 1'b0;
    repeat (2) run_sweep("pre_async");
    chk("pre_async box", 32'(box), 32'(9'b000000001));
    chk("pre_async super", 32'(super_on), 1);
    repeat (SCAN_DIV + 1) @(posedge clk);
    #1;
    chk("pre_async col_n", 32'(col_n), 32'(3'b101));
    #2;
    rst = 1'b0;
    #1;
    chk("async box", 32'(box), 0);
    chk("async super", 32'(super_on), 0);
    chk("async col_n", 32'(col_n), 32'(3'b110));
    chk("async box_changed", 32'(box_changed), 0);
    do_reset();
    run_sweep("resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/box_pad_scanner.md
Name: box_pad_scanner

Overview:
- Input front end for the 3x3 fire/gold game: scans a 3x3 active-low matrix of floor pads and produces the debounced 9-bit `box` occupancy bitmap consumed by the game controller.
- Also debounces the start button and super switch. Emits a one-cycle `start` pulse and a `super` level.
- Sits between board I/O pins and the game controller, in the same clock domain as the controller's `clk`.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven; legal range ≥2.
- DEB_SWEEPS, 4, consecutive sweeps a key must differ from its output before the output toggles; legal range ≥1.
- MAX_KEYS, 2, sweeps with more than this many pads pressed are discarded (ghost rejection); legal range 1..9.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- row_n  in  3  matrix row sense lines, active-low, pulled up on board
- col_n  out  3  matrix column drive, active-low, exactly one bit low at all times
- start_btn_n  in  1  raw start button, active-low
- super_sw_n  in  1  raw super switch, active-low
- box  out  9  debounced pad bitmap; bit index = row*3 + col; 1 = pressed
- box_changed  out  1  one-cycle pulse in the cycle `box` takes a new value
- start  out  1  one-cycle pulse on the debounced press edge of the start button
- super  out  1  debounced super switch level, 1 = active

Behaviour:
- Reset (rst=0, asynchronous) forces the following:
  - FSM state to SCAN_C0, col_n=3'b110, dwell counter 0.
  - Snapshot and all debounce counters to 0.
  - box=0, box_changed=0, start=0, super=0.
- Releasing reset starts scanning on the next rising clk edge.
- FSM states: SCAN_C0 -> SCAN_C1 -> SCAN_C2 -> UPDATE -> SCAN_C0.
  - SCAN_Cn drives col_n with bit n low for exactly SCAN_DIV cycles.
  - UPDATE lasts 1 cycle and holds col_n=3'b110.
  - Sweep period = 3*SCAN_DIV + 1 cycles.
- Row sampling:
  - Sampling happens only on the last dwell cycle of each SCAN_Cn; earlier cycles are settling time.
  - snap[r*3+n] <= ~row_n[r].
- UPDATE cycle, applied in this order:
  - start_btn_n and super_sw_n are sampled into the snapshot.
  - popcount(snap[8:0]) is computed. If it is > MAX_KEYS, the 9 pad counters and box are held unchanged. The button and switch debouncers still update.
  - Each debounced bit k: if snap[k]==out[k], cnt[k] <= 0. Otherwise cnt[k] <= cnt[k]+1.
  - When the incremented count equals DEB_SWEEPS, out[k] toggles and cnt[k] clears.
  - Counter width is clog2(DEB_SWEEPS+1). Counters never wrap.
- Output timing:
  - box, super and the internal debounced start level register at the end of UPDATE, so they change in the cycle after UPDATE.
  - box_changed=1 in that same cycle if box differs from its previous value; otherwise 0.
  - start=1 in that same cycle only if the debounced start level went 0->1. Holding the button produces no repeat pulses.
- Latency: a clean press that becomes stable mid-sweep appears on box between DEB_SWEEPS and DEB_SWEEPS+1 sweeps later.
- Simultaneous events:
  - A key press and a key release in the same sweep are both applied in the same UPDATE.
  - A single box_changed pulse covers all bits that changed.
- Mid-operation reset aborts the sweep with no output glitch beyond the reset values.
- col_n never has more than one bit low, including on the reset edge and at state transitions.

Decomposition:
- Shared package game_pkg holds:
  - constants N_ROWS=3, N_COLS=3, N_PADS=9;
  - the scan FSM state enum (SCAN_C0, SCAN_C1, SCAN_C2, UPDATE);
  - a key-index helper constant table row*3+col.
- One sub-module, sweep_debounce: a 1-bit sweep-count debouncer with inputs clk, rst, en (UPDATE strobe), hold, sample and output out. It is instantiated 11 times (9 pads, start, super).
- The top level contains the scan FSM, dwell counter, snapshot, popcount/ghost check and edge detectors.

Test Plan (SCAN_DIV=4, DEB_SWEEPS=2, MAX_KEYS=2; sweep = 13 cycles):
- Reset: assert rst=0 for 3 cycles -> box=0, box_changed=0, start=0, super=0, col_n=3'b110. After release, col_n steps 110->101->011 every 4 cycles, then holds 110 for the UPDATE cycle.
- Single pad: the bench model pulls row_n[1] low whenever col_n[2]=0 -> after the 2nd UPDATE, box=9'b000100000 with exactly one box_changed pulse. On release, box returns to 0 after 2 further sweeps, with one pulse.
- Bounce: press pad 0 for 1 sweep only, then release -> box stays 0 and box_changed never asserts.
- Ghost rejection: press pads 0, 4 and 8 together for 4 sweeps -> box stays 0. Then release pad 8 -> box=9'b000010001 two sweeps later.
- Buttons: hold start_btn_n=0 and super_sw_n=0 for 5 sweeps -> start is high for exactly 1 cycle, 2 sweeps in; super=1 from the same cycle until 2 sweeps after release.
- Async reset mid-sweep: with box=9'b000000001, pull rst low during SCAN_C1 between clock edges -> box, super and col_n reset immediately, without waiting for a clock edge.
